mem_bus: RTL and testbench

Memory and peripheral bus slave sitting directly downstream of the CPU core. It accepts one CPU request per `mem_init` strobe and serves it from on-chip synchronous block RAM or a small I/O region (timer and GPIO). It performs byte-lane steering for stores and sign/zero extension for loads, then returns completion via a one-cycle `mem_ready` pulse. It also drives the core's `irq` input from a memory-mapped timer compare.

---
 rtl/mem_bus.sv | 170 +++++++++++++++++
 tb/tb_mem_bus.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/mem_bus.sv
// rtl/mem_bus.sv - CPU-facing bus slave: block RAM, GPIO and timer with 2-cycle fixed latency.
// Byte-lane steering for stores, sign/zero extension for loads, registered timer interrupt.
module mem_bus #(
    parameter int    RAM_WORDS = 4096,
    parameter string INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_init,
    input  logic [2:0]  mem_read_op,
    input  logic [1:0]  mem_write_op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        mem_ready,
    output logic        irq,
    output logic [7:0]  gpio_out
);
    localparam int AW = $clog2(RAM_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, wdata_q;
    logic [2:0]  rop_q;
    logic [1:0]  wop_q;
    logic [31:0] rdata_hold_q;
    logic [31:0] ram_rdata_q;
    logic [31:0] io_rdata_q;
    logic [7:0]  gpio_q;
    logic [31:0] mtime_q, mtimecmp_q;
    logic        irq_q;

    logic [31:0] ram [0:RAM_WORDS-1];

    logic          is_io;
    logic [AW-1:0] ram_idx;
    logic          do_write, ram_we, io_we;
    logic [3:0]    be;
    logic [31:0]   wlane;
    logic [31:0]   io_word;
    logic [31:0]   src_word, shifted, load_val;
    logic [15:0]   half_v;
    logic [7:0]    byte_v;

    assign is_io   = addr_q[31];
    assign ram_idx = addr_q[AW+1:2];

    // Reset in ACCESS must suppress the commit, so the write strobe is gated by reset.
    assign do_write = (state_q == S_ACCESS) && (wop_q != 2'b00) && !reset;
    assign ram_we   = do_write && !is_io;
    assign io_we    = do_write && is_io && (wop_q == 2'b11);

    always_comb begin
        be    = 4'b0000;
        wlane = wdata_q;
        case (wop_q)
            2'b01: begin
                be    = 4'b0001 << addr_q[1:0];
                wlane = {4{wdata_q[7:0]}};
            end
            2'b10: begin
                be    = addr_q[1] ? 4'b1100 : 4'b0011;
                wlane = {2{wdata_q[15:0]}};
            end
            2'b11: be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (state_q == S_ACCESS) begin
            ram_rdata_q <= ram[ram_idx];
        end
        for (int i = 0; i < 4; i++) begin
            if (ram_we && be[i]) begin
                ram[ram_idx][8*i +: 8] <= wlane[8*i +: 8];
            end
        end
    end

    always_comb begin
        io_word = 32'd0;
        case (addr_q[3:2])
            2'd0:    io_word = {24'd0, gpio_q};
            2'd1:    io_word = mtime_q;
            2'd2:    io_word = mtimecmp_q;
            default: io_word = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gpio_q     <= 8'd0;
            mtime_q    <= 32'd0;
            mtimecmp_q <= 32'hFFFF_FFFF;
            irq_q      <= 1'b0;
            io_rdata_q <= 32'd0;
        end else begin
            mtime_q <= mtime_q + 32'd1;
            irq_q   <= (mtime_q >= mtimecmp_q);
            if (state_q == S_ACCESS) begin
                io_rdata_q <= io_word;
            end
            // A software load of mtime overrides the increment in the same cycle.
            if (io_we) begin
                case (addr_q[3:2])
                    2'd0:    gpio_q     <= wdata_q[7:0];
                    2'd1:    mtime_q    <= wdata_q;
                    2'd2:    mtimecmp_q <= wdata_q;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        src_word = is_io ? io_rdata_q : ram_rdata_q;
        shifted  = src_word >> {addr_q[1:0], 3'b000};
        byte_v   = shifted[7:0];
        half_v   = addr_q[1] ? src_word[31:16] : src_word[15:0];
        case (rop_q)
            3'b010:  load_val = {{16{half_v[15]}}, half_v};
            3'b011:  load_val = {16'd0, half_v};
            3'b100:  load_val = {{24{byte_v[7]}}, byte_v};
            3'b101:  load_val = {24'd0, byte_v};
            default: load_val = src_word;
        endcase
        if ((wop_q != 2'b00) || (rop_q == 3'b000)) begin
            load_val = 32'd0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (mem_init) state_d = S_ACCESS;
            S_ACCESS: state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            rdata_hold_q <= 32'd0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            rop_q        <= 3'd0;
            wop_q        <= 2'd0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && mem_init) begin
                addr_q  <= addr;
                wdata_q <= wdata;
                rop_q   <= mem_read_op;
                wop_q   <= mem_write_op;
            end
            if (state_q == S_DONE) begin
                rdata_hold_q <= load_val;
            end
        end
    end

    assign mem_ready = (state_q == S_DONE);
    assign rdata     = (state_q == S_DONE) ? load_val : rdata_hold_q;
    assign irq       = irq_q;
    assign gpio_out  = gpio_q;
endmodule

// File: tb/tb_mem_bus.sv
// tb/tb_mem_bus.sv - directed scoreboard bench for mem_bus.
module tb_mem_bus;
    localparam logic [2:0] RD_NONE = 3'b000, RD_W = 3'b001, RD_HS = 3'b010, RD_HU = 3'b011,
                           RD_BS = 3'b100, RD_BU = 3'b101;
    localparam logic [1:0] WR_NONE = 2'b00, WR_B = 2'b01, WR_H = 2'b10, WR_W = 2'b11;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_init = 1'b0;
    logic [2:0]  mem_read_op = 3'd0;
    logic [1:0]  mem_write_op = 2'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic        mem_ready;
    logic        irq;
    logic [7:0]  gpio_out;

    int checks = 0;
    int errors = 0;
    logic [31:0] sb[$];

    mem_bus dut (
        .clk          (clk),
        .reset        (reset),
        .mem_init     (mem_init),
        .mem_read_op  (mem_read_op),
        .mem_write_op (mem_write_op),
        .addr         (addr),
        .wdata        (wdata),
        .rdata        (rdata),
        .mem_ready    (mem_ready),
        .irq          (irq),
        .gpio_out     (gpio_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic done_chk(input string tag);
        logic [31:0] e;
        e = (sb.size() > 0) ? sb.pop_front() : 32'hxxxx_xxxx;
        chk({tag, "_rdy"}, {31'd0, mem_ready}, 32'd1);
        chk({tag, "_rdata"}, rdata, e);
    endtask

    task automatic drive(input logic [2:0] rop, input logic [1:0] wop,
                         input logic [31:0] a, input logic [31:0] wd);
        mem_init     = 1'b1;
        mem_read_op  = rop;
        mem_write_op = wop;
        addr         = a;
        wdata        = wd;
    endtask

    task automatic idle_inputs();
        mem_init     = 1'b0;
        mem_read_op  = 3'd0;
        mem_write_op = 2'd0;
    endtask

    task automatic req(input string tag, input logic [2:0] rop, input logic [1:0] wop,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] exp);
        @(negedge clk);
        drive(rop, wop, a, wd);
        sb.push_back(exp);
        @(negedge clk);
        idle_inputs();
        chk({tag, "_acc_rdy"}, {31'd0, mem_ready}, 32'd0);
        @(negedge clk);
        done_chk(tag);
    endtask

    initial begin
        int k;
        repeat (3) @(negedge clk);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_ready", {31'd0, mem_ready}, 32'd0);
        chk("rst_gpio", {24'd0, gpio_out}, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        reset = 1'b0;

        req("sw100", RD_NONE, WR_W, 32'h100, 32'h1234_5678, 32'd0);
        req("lw100", RD_W, WR_NONE, 32'h100, 32'd0, 32'h1234_5678);
        chk("rdata_hold", rdata, 32'h1234_5678);
        req("sb102", RD_NONE, WR_B, 32'h102, 32'hFFFF_FFAB, 32'd0);
        req("lb102", RD_BS, WR_NONE, 32'h102, 32'd0, 32'hFFFF_FFAB);
        req("lbu102", RD_BU, WR_NONE, 32'h102, 32'd0, 32'h0000_00AB);
        req("lw100b", RD_W, WR_NONE, 32'h100, 32'd0, 32'h12AB_5678);
        req("lw_alias", RD_W, WR_NONE, 32'h4100, 32'd0, 32'h12AB_5678);

        req("sw104", RD_NONE, WR_W, 32'h104, 32'h1122_3344, 32'd0);
        req("sh106", RD_NONE, WR_H, 32'h106, 32'h0000_8001, 32'd0);
        req("lh106", RD_HS, WR_NONE, 32'h106, 32'd0, 32'hFFFF_8001);
        req("lhu106", RD_HU, WR_NONE, 32'h106, 32'd0, 32'h0000_8001);
        req("lh105", RD_HS, WR_NONE, 32'h105, 32'd0, 32'h0000_3344);
        req("lw107", RD_W, WR_NONE, 32'h107, 32'd0, 32'h8001_3344);
        req("lw_op7", 3'b111, WR_NONE, 32'h104, 32'd0, 32'h8001_3344);

        req("combo", RD_W, WR_W, 32'h108, 32'hCAFE_F00D, 32'd0);
        req("lw108", RD_W, WR_NONE, 32'h108, 32'd0, 32'hCAFE_F00D);
        req("noop", RD_NONE, WR_NONE, 32'h108, 32'd0, 32'd0);

        req("sw_gpio", RD_NONE, WR_W, 32'h8000_0000, 32'h0000_005A, 32'd0);
        chk("gpio_word", {24'd0, gpio_out}, 32'h5A);
        req("sb_gpio", RD_NONE, WR_B, 32'h8000_0000, 32'h0000_00FF, 32'd0);
        chk("gpio_byte_ign", {24'd0, gpio_out}, 32'h5A);
        req("lw_gpio", RD_W, WR_NONE, 32'h8000_0000, 32'd0, 32'h0000_005A);
        req("lw_unmap", RD_W, WR_NONE, 32'h8000_000C, 32'd0, 32'd0);

        req("w_mtime", RD_NONE, WR_W, 32'h8000_0004, 32'd0, 32'd0);
        req("w_cmp", RD_NONE, WR_W, 32'h8000_0008, 32'd20, 32'd0);
        k = 0;
        while (!irq && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("irq_delay", k, 32'd18);
        req("w_cmp_max", RD_NONE, WR_W, 32'h8000_0008, 32'hFFFF_FFFF, 32'd0);
        chk("irq_still_hi", {31'd0, irq}, 32'd1);
        @(negedge clk);
        chk("irq_drop", {31'd0, irq}, 32'd0);
        req("lw_cmp", RD_W, WR_NONE, 32'h8000_0008, 32'd0, 32'hFFFF_FFFF);

        req("sw200", RD_NONE, WR_W, 32'h200, 32'h0102_0304, 32'd0);
        @(negedge clk);
        drive(RD_NONE, WR_W, 32'h200, 32'hDEAD_BEEF);
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_acc_rdy", {31'd0, mem_ready}, 32'd0);
        chk("rst_acc_gpio", {24'd0, gpio_out}, 32'd0);
        chk("rst_acc_rdata", rdata, 32'd0);
        @(negedge clk);
        chk("rst_acc_rdy2", {31'd0, mem_ready}, 32'd0);
        req("lw200", RD_W, WR_NONE, 32'h200, 32'd0, 32'h0102_0304);

        @(negedge clk);
        drive(RD_W, WR_NONE, 32'h100, 32'd0);
        sb.push_back(32'h12AB_5678);
        @(negedge clk);
        drive(RD_NONE, WR_W, 32'h100, 32'hBAD0_BAD0);
        chk("dup_acc_rdy", {31'd0, mem_ready}, 32'd0);
        @(negedge clk);
        done_chk("dup");
        @(negedge clk);
        idle_inputs();
        chk("dup_n3_rdy", {31'd0, mem_ready}, 32'd0);
        @(negedge clk);
        chk("dup_n4_rdy", {31'd0, mem_ready}, 32'd0);
        req("lw100_after_dup", RD_W, WR_NONE, 32'h100, 32'd0, 32'h12AB_5678);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
